// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu_ctrl control core: state encoding,
// instruction field layout and the halt / retire-counter limits.
package cpu_pkg;

  localparam int DATA_WIDTH       = 8;
  localparam int BUS_WIDTH        = 8;
  localparam int OPCODE_WIDTH     = 6;
  localparam int PC_WIDTH         = 8;
  localparam int IMEM_TIMEOUT_DEF = 15;

  // Instruction word is {opcode, addr1, addr2, dest}, dest in the low bits.
  localparam int INSTR_W = OPCODE_WIDTH + 3*BUS_WIDTH;
  localparam int DST_LSB = 0;
  localparam int A2_LSB  = BUS_WIDTH;
  localparam int A1_LSB  = 2*BUS_WIDTH;
  localparam int OP_LSB  = 3*BUS_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] HALT_OP     = '1;
  localparam logic [15:0]             RETIRED_MAX = 16'hFFFF;

  typedef enum logic [3:0] {
    SIDLE, SFETCH, SDECODE, SREAD, SCALC, SWRITE, SHALT, SFAULT
`ifdef CPU_SINGLE_STEP_EN
    , SPAUSE
`endif
  } state_t;

endpackage

// File: rtl/cpu_if.sv
// Bus bundle between cpu_ctrl (master) and the imem / register file / ALU (slave).
interface cpu_if;
  import cpu_pkg::*;

  logic                    imem_req;
  logic [PC_WIDTH-1:0]     imem_addr;
  logic                    imem_ack;
  logic [INSTR_W-1:0]      imem_data;

  logic [BUS_WIDTH-1:0]    rf_raddr1, rf_raddr2;
  logic [DATA_WIDTH-1:0]   rf_rdata1, rf_rdata2;
  logic                    rf_we;
  logic [BUS_WIDTH-1:0]    rf_waddr;
  logic [DATA_WIDTH-1:0]   rf_wdata;

  logic                    alu_en;
  logic [OPCODE_WIDTH-1:0] alu_opcode;
  logic [DATA_WIDTH-1:0]   alu_value1, alu_value2;
  logic [BUS_WIDTH-1:0]    alu_addr1, alu_addr2;
  logic [DATA_WIDTH-1:0]   alu_result;
  logic                    alu_calc_done;
  logic                    alu_err;

  modport master (
    output imem_req, imem_addr, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
           alu_en, alu_opcode, alu_value1, alu_value2, alu_addr1, alu_addr2,
    input  imem_ack, imem_data, rf_rdata1, rf_rdata2, alu_result, alu_calc_done, alu_err
  );

  modport slave (
    input  imem_req, imem_addr, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
           alu_en, alu_opcode, alu_value1, alu_value2, alu_addr1, alu_addr2,
    output imem_ack, imem_data, rf_rdata1, rf_rdata2, alu_result, alu_calc_done, alu_err
  );

endinterface

// File: rtl/cpu_fetch.sv
// Instruction fetch: imem req/ack handshake, unacked-cycle timeout and instruction latch.
module cpu_fetch
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = IMEM_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               fetch_go,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               imem_req,
  output logic               instr_valid,
  output logic               timeout,
  output logic [INSTR_W-1:0] instr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // An ack in the last allowed cycle is accepted, so timeout requires no ack.
  assign imem_req    = fetch_go;
  assign instr_valid = fetch_go & imem_ack;
  assign timeout     = fetch_go & ~imem_ack & (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      instr <= '0;
    end else begin
      if (!fetch_go)     cnt <= '0;
      else if (!imem_ack) cnt <= cnt + 1'b1;
      if (instr_valid)   instr <= imem_data;
    end
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Top-level control FSM: fetch, decode, register read, ALU calc, writeback.
// Optional single-step mode (SPAUSE after each writeback) under CPU_SINGLE_STEP_EN.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int IMEM_TIMEOUT = IMEM_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
`ifdef CPU_SINGLE_STEP_EN
  input  logic                step,
`endif
  cpu_if.master               bus,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                halted,
  output logic                fault,
  output logic [15:0]         retired
);

  state_t state, nxt;

  logic                    fetch_go, instr_valid, timeout;
  logic [INSTR_W-1:0]      instr;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [BUS_WIDTH-1:0]    addr1, addr2, dest;
  logic [DATA_WIDTH-1:0]   val1, val2;

  assign opcode = instr[OP_LSB  +: OPCODE_WIDTH];
  assign addr1  = instr[A1_LSB  +: BUS_WIDTH];
  assign addr2  = instr[A2_LSB  +: BUS_WIDTH];
  assign dest   = instr[DST_LSB +: BUS_WIDTH];

  assign fetch_go = (state == SFETCH);

  cpu_fetch #(.TIMEOUT(IMEM_TIMEOUT)) u_fetch (
    .clk        (clk),
    .rstn       (rstn),
    .fetch_go   (fetch_go),
    .imem_ack   (bus.imem_ack),
    .imem_data  (bus.imem_data),
    .imem_req   (bus.imem_req),
    .instr_valid(instr_valid),
    .timeout    (timeout),
    .instr      (instr)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= SIDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt        = state;
    bus.rf_we  = 1'b0;
    bus.alu_en = 1'b0;
    case (state)
      SIDLE:   if (start) nxt = SFETCH;
      SFETCH:  if (instr_valid) nxt = SDECODE;
               else if (timeout) nxt = SFAULT;
      SDECODE: nxt = (opcode == HALT_OP) ? SHALT : SREAD;
      SREAD:   nxt = SCALC;
      SCALC: begin
        bus.alu_en = bus.alu_calc_done;
        if (bus.alu_err)            nxt = SFAULT;
        else if (bus.alu_calc_done) nxt = SWRITE;
      end
      SWRITE: begin
        bus.rf_we = 1'b1;
`ifdef CPU_SINGLE_STEP_EN
        nxt = SPAUSE;
`else
        nxt = SFETCH;
`endif
      end
`ifdef CPU_SINGLE_STEP_EN
      SPAUSE:  if (step) nxt = SFETCH;
`endif
      default: nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      val1    <= '0;
      val2    <= '0;
      pc      <= '0;
      retired <= '0;
    end else begin
      if (state == SREAD) begin
        val1 <= bus.rf_rdata1;
        val2 <= bus.rf_rdata2;
      end
      if (state == SWRITE) begin
        pc <= pc + 1'b1;
        if (retired != RETIRED_MAX) retired <= retired + 1'b1;
      end
    end
  end

  assign bus.imem_addr  = pc;
  assign bus.rf_raddr1  = addr1;
  assign bus.rf_raddr2  = addr2;
  assign bus.rf_waddr   = dest;
  assign bus.rf_wdata   = bus.alu_result;
  assign bus.alu_opcode = opcode;
  assign bus.alu_value1 = val1;
  assign bus.alu_value2 = val2;
  assign bus.alu_addr1  = addr1;
  assign bus.alu_addr2  = addr2;

  assign busy   = state inside {SFETCH, SDECODE, SREAD, SCALC, SWRITE};
  assign halted = (state == SHALT);
  assign fault  = (state == SFAULT);

endmodule
